// File: rtl/s2p.sv
// Serial-to-parallel converter: collects N bits LSB first and presents them as one word.
// Optional mid-word idle timeout is built when S2P_TIMEOUT_EN is defined.
module s2p #(
  parameter int N       = 4,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ser_data,
  input  logic         ser_valid,
  output logic         ser_ready,
  output logic [N-1:0] par_data,
  output logic         par_valid,
  input  logic         par_ready,
  output logic         err
);

  localparam int CW = $clog2(N);

  if (N < 2 || N > 32) begin : g_bad_n
    $error("s2p: N out of range");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("s2p: TIMEOUT out of range");
  end

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   shreg;
  logic [N-1:0]   word_next;
  logic           bit_hs;
  logic           word_hs;
  logic           last_bit;
  logic           timeout_hit;

  // A transfer happens only on a rising edge where valid and ready are both 1;
  // ready never looks at valid, and valid is never withdrawn by this block once raised.
  assign par_valid = (state == FULL);
  assign ser_ready = ~rst & (~par_valid | par_ready);
  assign bit_hs    = ser_valid & ser_ready;
  assign word_hs   = par_valid & par_ready;
  assign last_bit  = (cnt == CW'(N - 1));

  always_comb begin
    word_next      = shreg;
    word_next[cnt] = ser_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= COLLECT;
      cnt      <= '0;
      shreg    <= '0;
      par_data <= '0;
    end else begin
      if (bit_hs && last_bit) begin
        state <= FULL;
      end else if (word_hs) begin
        state <= COLLECT;
      end

      if (bit_hs) begin
        if (last_bit) begin
          par_data <= word_next;
          cnt      <= '0;
          shreg    <= '0;
        end else begin
          shreg <= word_next;
          cnt   <= cnt + CW'(1);
        end
      end else if (timeout_hit) begin
        cnt   <= '0;
        shreg <= '0;
      end
    end
  end

`ifdef S2P_TIMEOUT_EN
  logic [7:0] idle_cnt;

  // Fires on the edge that closes the TIMEOUT-th idle cycle, so err shows one cycle later.
  assign timeout_hit = (cnt != '0) && !bit_hs && (idle_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= timeout_hit;
      if (bit_hs || cnt == '0 || timeout_hit) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 8'd1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_s2p.sv
// Self-checking bench for s2p: directed scenarios plus randomized traffic against a
// bit-queue reference model and a word scoreboard.
module tb_s2p;

  localparam int N       = 4;
  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         ser_data;
  logic         ser_valid;
  logic         ser_ready;
  logic [N-1:0] par_data;
  logic         par_valid;
  logic         par_ready;
  logic         err;

  int checks   = 0;
  int failures = 0;
  int err_seen = 0;

  // Reference model state: bits of the word in progress, presented word, idle count.
  logic         part_q[$];
  logic [N-1:0] exp_q[$];
  logic         m_pv;
  logic [N-1:0] m_pd;
  logic         m_err;
  int           m_idle;

  s2p #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .ser_data  (ser_data),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .par_data  (par_data),
    .par_valid (par_valid),
    .par_ready (par_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic         rdy;
    logic         bhs;
    logic         nxt_pv;
    logic         nxt_err;
    logic [N-1:0] w;
    if (rst) begin
      part_q.delete();
      exp_q.delete();
      m_pv   = 1'b0;
      m_pd   = '0;
      m_err  = 1'b0;
      m_idle = 0;
      return;
    end
    rdy     = !m_pv || par_ready;
    bhs     = ser_valid && rdy;
    nxt_pv  = (m_pv && par_ready) ? 1'b0 : m_pv;
    nxt_err = 1'b0;
    if (bhs) begin
      part_q.push_back(ser_data);
      m_idle = 0;
      if (part_q.size() == N) begin
        w = '0;
        for (int k = 0; k < N; k++) w[k] = part_q[k];
        m_pd   = w;
        nxt_pv = 1'b1;
        exp_q.push_back(w);
        part_q.delete();
      end
    end else begin
`ifdef S2P_TIMEOUT_EN
      if (part_q.size() > 0) begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          part_q.delete();
          m_idle  = 0;
          nxt_err = 1'b1;
        end
      end else begin
        m_idle = 0;
      end
`endif
    end
    m_pv  = nxt_pv;
    m_err = nxt_err;
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, advance the model.
  task automatic cycle(input logic r, input logic sv, input logic sd, input logic pr);
    rst       = r;
    ser_valid = sv;
    ser_data  = sd;
    par_ready = pr;
    @(negedge clk);
    check_eq("ser_ready", ser_ready, (!r) && (!m_pv || pr));
    check_eq("par_valid", par_valid, m_pv);
    check_eq("par_data", par_data, m_pd);
    check_eq("err", err, m_err);
    if (err) err_seen++;
    if (!r && par_valid && par_ready) begin
      if (exp_q.size() > 0) check_eq("sb_word", par_data, exp_q.pop_front());
      else check_eq("sb_word_pending", exp_q.size(), 1);
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [N-1:0] bits, input int cnt_bits, input logic pr);
    for (int i = 0; i < cnt_bits; i++) cycle(1'b0, 1'b1, bits[i], pr);
  endtask

  initial begin
    m_pv = 1'b0; m_pd = '0; m_err = 1'b0; m_idle = 0;
    rst = 1'b1; ser_valid = 1'b0; ser_data = 1'b0; par_ready = 1'b1;

    repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("reset_par_data", par_data, 0);
    check_eq("reset_par_valid", par_valid, 0);

    // 0,1,0,1 -> 4'b1010, valid one cycle after the last bit, then gone
    send_bits(4'b1010, 4, 1'b1);
    check_eq("w1010_data", par_data, 4'b1010);
    check_eq("w1010_valid", par_valid, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("w1010_drop", par_valid, 0);

    // back-to-back 1011 then 0001 at full rate
    send_bits(4'b1011, 4, 1'b1);
    check_eq("b2b_first", par_data, 4'b1011);
    check_eq("b2b_first_v", par_valid, 1);
    send_bits(4'b0001, 1, 1'b1);
    check_eq("b2b_gap_v", par_valid, 0);
    send_bits(4'b0000, 3, 1'b1);
    check_eq("b2b_second", par_data, 4'b0001);
    check_eq("b2b_second_v", par_valid, 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // backpressure: 1111 held for 3 cycles, then handshake with next bit accepted
    send_bits(4'b1111, 4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("bp_hold_data", par_data, 4'b1111);
      check_eq("bp_hold_valid", par_valid, 1);
      check_eq("bp_ready_low", ser_ready, 0);
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("bp_release", par_valid, 0);
    send_bits(4'b0110, 3, 1'b1);
    check_eq("bp_next_word", par_data, 4'b1101);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // reset mid-word discards the partial bits
    send_bits(4'b0011, 2, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("rst_mid_data", par_data, 0);
    send_bits(4'b0110, 4, 1'b1);
    check_eq("rst_new_word", par_data, 4'b0110);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // two bits, 16 idle cycles, then 0,0,1,1
    err_seen = 0;
    send_bits(4'b0011, 2, 1'b1);
    repeat (TIMEOUT) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(4'b1100, 4, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef S2P_TIMEOUT_EN
    check_eq("to_err_pulses", err_seen, 1);
    check_eq("to_word", par_data, 4'b1100);
`else
    check_eq("to_err_pulses", err_seen, 0);
    check_eq("to_word", par_data, 4'b0011);
`endif

    // randomized traffic, alternating dense and sparse serial input
    for (int i = 0; i < 3000; i++) begin
      logic r, sv, pr;
      r  = ($urandom_range(0, 149) == 0);
      if ((i / 500) % 2 == 1) sv = ($urandom_range(0, 7) == 0);
      else sv = ($urandom_range(0, 3) != 0);
      pr = ($urandom_range(0, 3) != 0);
      cycle(r, sv, 1'($urandom_range(0, 1)), pr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/s2p.md
S2P -- requirements
Module: s2p

Interface
REQ-001 Parameter N, default 4, word width in bits; legal range 2..32.
REQ-002 Parameter TIMEOUT, default 16, idle cycles allowed mid-word before the partial word is discarded; legal range 1..255; used only with S2P_TIMEOUT_EN.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ser_data  input  1  serial data bit from upstream p2s.
REQ-006 ser_valid  input  1  ser_data valid.
REQ-007 ser_ready  output  1  block accepts a bit this cycle.
REQ-008 par_data  output  N  assembled word.
REQ-009 par_valid  output  1  par_data holds a complete word.
REQ-010 par_ready  input  1  downstream accepts par_data this cycle.
REQ-011 err  output  1  one-cycle pulse when a partial word is discarded by timeout.

Function
REQ-012 Bit handshake occurs when ser_valid and ser_ready are both 1 at a rising edge; word handshake occurs when par_valid and par_ready are both 1.
REQ-013 Bits are LSB first: the k-th accepted bit of a word (k = 0..N-1) lands in par_data[k].
REQ-014 The block holds a bit counter cnt (0..N-1) and a shift register; state is COLLECT while par_valid = 0 and FULL while par_valid = 1.
REQ-015 ser_ready = (not par_valid) or par_ready, forced to 0 while rst = 1; combinational, no dependence on ser_valid.
REQ-016 On a bit handshake with cnt < N-1: store the bit, cnt increments; par_valid and par_data unchanged.
REQ-017 On a bit handshake with cnt = N-1: par_data loads the complete word, par_valid = 1 from the next cycle, cnt = 0; latency from last-bit handshake to par_valid is exactly 1 cycle.
REQ-018 While par_valid = 1 and par_ready = 0: par_data and par_valid hold stable, ser_ready = 0, no bits accepted.
REQ-019 On a word handshake with no completing bit in the same cycle, par_valid = 0 next cycle.
REQ-020 Word handshake and bit handshake in the same cycle are both honoured; the bit counts toward the next word with no lost cycle, giving full throughput of one word every N cycles.
REQ-021 ser_valid = 0 inserts bubbles; cnt and partial data hold, subject to the timeout rule in REQ-026.
REQ-022 par_data is not modified outside REQ-017; the partial word is kept in a separate shift register.

Reset
REQ-023 While rst = 1 at a rising edge: cnt = 0, shift register = 0, par_data = 0, par_valid = 0, err = 0, timeout counter = 0.
REQ-024 Reset mid-word or while FULL discards all held data; the first bit accepted after reset is bit 0 of a new word.
REQ-025 ser_ready = 0 in every cycle rst = 1, and equals 1 in the first cycle after rst deasserts.

Configuration
REQ-026 With macro S2P_TIMEOUT_EN defined:
- An idle counter increments each cycle with cnt > 0 and no bit handshake.
- The idle counter clears on any bit handshake, or when cnt = 0.
- When the idle counter reaches TIMEOUT: cnt = 0, the partial word is discarded, err = 1 for exactly one cycle, and the idle counter clears.
- par_valid and par_data are unaffected.
REQ-027 Without S2P_TIMEOUT_EN: no idle counter is built, err is tied to 0, partial words wait indefinitely.

Verification
REQ-028 Stream bits 0,1,0,1 (N=4) with ser_valid continuous and par_ready = 1 -> par_data = 4'b1010 and par_valid = 1 one cycle after the 4th handshake, then par_valid = 0.
REQ-029 Two words 1011 then 0001, back-to-back with par_ready = 1 -> par_valid pulses once per word, 4 cycles apart, and ser_ready stays 1 throughout.
REQ-030 Word 1111 completes while par_ready = 0 for 3 cycles -> ser_ready = 0 and par_data stable at 4'b1111 for 3 cycles; handshake on the 4th cycle with the next bit accepted in the same cycle.
REQ-031 Assert rst after 2 bits of a word, then send 0,1,1,0 -> par_data = 4'b0110 with no trace of the earlier bits; all outputs 0 during rst.
REQ-032 With S2P_TIMEOUT_EN and TIMEOUT = 16: send 2 bits, idle 16 cycles, then send 0,0,1,1 -> err pulses once on the 16th idle cycle and par_data = 4'b1100. Without the macro, the same stimulus -> err stays 0 and par_data = 4'b0011 after the 2 stale bits (1,1 completing on the 2nd new bit pair pattern per REQ-013).
